// File: rtl/serial_tx.sv
`default_nettype none
// ============================================================================
//  Module   : serial_tx
//  Purpose  : UART-style frame transmitter. A frame is a start bit (0), the
//             data bits LSB first, an optional even-parity bit and a stop
//             bit (1). Every bit is held on tx for CLKS_PER_BIT clocks.
//  Options  : SERIAL_TX_PARITY_EN - inserts the even-parity bit after DATA.
//  Revision : 1.0 - initial release
// ============================================================================
module serial_tx #(
  parameter int DATA_WIDTH   = 8,
  parameter int CLKS_PER_BIT = 16
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] data,
  input  logic                  start,
  output logic                  tx,
  output logic                  busy,
  output logic                  done
);

  localparam int c_cnt_w = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int c_idx_w = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(CLKS_PER_BIT - 1);
  localparam logic [c_idx_w-1:0] c_idx_last = c_idx_w'(DATA_WIDTH - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4
  } state_t;

  state_t                r_state;
  logic [c_cnt_w-1:0]    r_cnt;
  logic [c_idx_w-1:0]    r_idx;
  logic [DATA_WIDTH-1:0] r_shift;
  logic                  r_tx;
  logic                  r_busy;
  logic                  r_done;

  logic                  w_bit_end;
  logic [DATA_WIDTH-1:0] w_shift_next;
  state_t                w_post_data_state;
  logic                  w_post_data_tx;

  assign w_bit_end    = (r_cnt == c_cnt_last);
  assign w_shift_next = r_shift >> 1;

`ifdef SERIAL_TX_PARITY_EN
  // Parity is taken from the word at accept time so later data changes
  // cannot leak into the frame in flight.
  logic r_parity;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_parity <= 1'b0;
    end else if (r_state == S_IDLE && start) begin
      r_parity <= ^data;
    end
  end

  assign w_post_data_state = S_PARITY;
  assign w_post_data_tx    = r_parity;
`else
  assign w_post_data_state = S_STOP;
  assign w_post_data_tx    = 1'b1;
`endif

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_idx   <= '0;
      r_shift <= '0;
      r_tx    <= 1'b1;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          r_tx  <= 1'b1;
          r_cnt <= '0;
          r_idx <= '0;
          if (start) begin
            r_shift <= data;
            r_state <= S_START;
            r_tx    <= 1'b0;
            r_busy  <= 1'b1;
          end
        end

        S_START: begin
          if (w_bit_end) begin
            r_cnt   <= '0;
            r_state <= S_DATA;
            r_tx    <= r_shift[0];
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end

        S_DATA: begin
          if (w_bit_end) begin
            r_cnt <= '0;
            if (r_idx == c_idx_last) begin
              r_state <= w_post_data_state;
              r_tx    <= w_post_data_tx;
            end else begin
              r_idx   <= r_idx + 1'b1;
              r_shift <= w_shift_next;
              r_tx    <= w_shift_next[0];
            end
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end

`ifdef SERIAL_TX_PARITY_EN
        S_PARITY: begin
          if (w_bit_end) begin
            r_cnt   <= '0;
            r_state <= S_STOP;
            r_tx    <= 1'b1;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
`endif

        S_STOP: begin
          r_tx <= 1'b1;
          // The done cycle is spent in IDLE, so a start seen then chains
          // the next frame straight after this stop bit.
          if (w_bit_end) begin
            r_cnt   <= '0;
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end

        default: begin
          r_state <= S_IDLE;
          r_cnt   <= '0;
          r_tx    <= 1'b1;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign tx   = r_tx;
  assign busy = r_busy;
  assign done = r_done;

endmodule
`default_nettype wire

// File: tb/tb_serial_tx.sv
`default_nettype none
// ============================================================================
//  Module   : tb_serial_tx
//  Purpose  : Self-checking bench for serial_tx (8-bit, 4 and 1 clocks/bit).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_serial_tx;

  localparam int c_dw  = 8;
  localparam int c_cpb = 4;
`ifdef SERIAL_TX_PARITY_EN
  localparam int c_par = 1;
`else
  localparam int c_par = 0;
`endif
  localparam int c_nbits = 2 + c_dw + c_par;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] r_data = 8'h00;
  logic       r_start = 1'b0;
  logic       w_tx, w_busy, w_done;
  logic [7:0] r_fdata = 8'h00;
  logic       r_fstart = 1'b0;
  logic       w_ftx, w_fbusy, w_fdone;

  int total = 0;
  int bad   = 0;

  always #5 clock = ~clock;

  serial_tx #(.DATA_WIDTH(c_dw), .CLKS_PER_BIT(c_cpb)) u_dut (
    .clock(clock), .reset(reset), .data(r_data), .start(r_start),
    .tx(w_tx), .busy(w_busy), .done(w_done)
  );

  serial_tx #(.DATA_WIDTH(c_dw), .CLKS_PER_BIT(1)) u_fast (
    .clock(clock), .reset(reset), .data(r_fdata), .start(r_fstart),
    .tx(w_ftx), .busy(w_fbusy), .done(w_fdone)
  );

  task automatic check(input string name, input logic act, input logic exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a frame is a list of line bits; the line level k cycles
  // after acceptance is bit k/CLKS_PER_BIT, followed by one done cycle.
  bit m_active = 1'b0;
  bit m_done   = 1'b0;
  int m_cyc    = 0;
  bit m_bits[16];
  bit chk_en   = 1'b0;

  always @(posedge clock or posedge reset) begin
    if (reset) begin
      m_active = 1'b0;
      m_done   = 1'b0;
      m_cyc    = 0;
    end else if (m_active) begin
      m_cyc++;
      if (m_cyc == c_nbits * c_cpb) begin
        m_active = 1'b0;
        m_done   = 1'b1;
      end
    end else begin
      m_done = 1'b0;
      if (r_start) begin
        m_bits[0] = 1'b0;
        for (int i = 0; i < c_dw; i++) m_bits[1+i] = r_data[i];
        m_bits[1+c_dw]    = ^r_data;
        m_bits[c_nbits-1] = 1'b1;
        m_active = 1'b1;
        m_cyc    = 0;
      end
    end
  end

  always @(negedge clock) begin
    if (chk_en) begin
      check("model_tx", w_tx, m_active ? m_bits[m_cyc / c_cpb] : 1'b1);
      check("model_busy", w_busy, m_active);
      check("model_done", w_done, m_done);
    end
  end

  task automatic wait_idle();
    int n = 0;
    while ((w_busy || w_done) && n < 200) begin
      @(negedge clock);
      n++;
    end
    if (n >= 200) check("idle_timeout", w_busy, 1'b0);
  endtask

  typedef struct {
    logic [7:0] data;
    logic       exp_par;
  } vec_t;

  vec_t vecs[6];
  bit   e6[$];

  initial begin
    int k;
    int dones;

    vecs[0] = '{8'hA5, 1'b0};
    vecs[1] = '{8'h07, 1'b1};
    vecs[2] = '{8'h03, 1'b0};
    vecs[3] = '{8'hFF, 1'b0};
    vecs[4] = '{8'h01, 1'b1};
    vecs[5] = '{8'h80, 1'b1};

    repeat (2) @(negedge clock);
    check("rst_tx", w_tx, 1'b1);
    check("rst_busy", w_busy, 1'b0);
    check("rst_done", w_done, 1'b0);
    check("rst_ftx", w_ftx, 1'b1);
    reset  = 1'b0;
    chk_en = 1'b1;
    repeat (3) @(negedge clock);

    // Table-driven single frames: frame length and the slot after the data bits
    for (int v = 0; v < 6; v++) begin
      wait_idle();
      r_data  = vecs[v].data;
      r_start = 1'b1;
      @(negedge clock);
      r_start = 1'b0;
      k = 0;
      while (k < 100 && !w_done) begin
        if (k == (1 + c_dw) * c_cpb + 1)
          check("bit9", w_tx, (c_par != 0) ? vecs[v].exp_par : 1'b1);
        @(negedge clock);
        k++;
      end
      check_int("frame_len", k, c_nbits * c_cpb);
    end

    // Asynchronous reset in the middle of data bit 3
    wait_idle();
    r_data  = 8'hC3;
    r_start = 1'b1;
    @(negedge clock);
    r_start = 1'b0;
    repeat ((1 + 3) * c_cpb + 1) @(negedge clock);
    check("pre_rst_tx", w_tx, 1'b0);
    #2 reset = 1'b1;
    #1;
    check("arst_tx", w_tx, 1'b1);
    check("arst_busy", w_busy, 1'b0);
    check("arst_done", w_done, 1'b0);
    @(negedge clock);
    @(negedge clock);
    reset = 1'b0;
    repeat (5) @(negedge clock);
    check("post_rst_busy", w_busy, 1'b0);

    // Start during a frame is ignored
    wait_idle();
    r_data  = 8'h3C;
    r_start = 1'b1;
    @(negedge clock);
    r_start = 1'b0;
    repeat (10) @(negedge clock);
    r_data  = 8'hFF;
    r_start = 1'b1;
    @(negedge clock);
    r_start = 1'b0;
    r_data  = 8'h00;
    dones = 0;
    repeat (60) begin
      @(negedge clock);
      if (w_done) dones++;
    end
    check_int("one_done", dones, 1);

    // Start held high: back-to-back frames 01 then 80
    wait_idle();
    r_data  = 8'h01;
    r_start = 1'b1;
    @(negedge clock);
    r_data = 8'h80;
    k = 0;
    while (!w_done && k < 100) begin
      @(negedge clock);
      k++;
    end
    check("b2b_done", w_done, 1'b1);
    @(negedge clock);
    r_start = 1'b0;
    check("b2b_busy", w_busy, 1'b1);
    check("b2b_tx", w_tx, 1'b0);
    wait_idle();

    // One clock per bit, data 5A
    e6 = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
    if (c_par != 0) e6.push_back(1'b0);
    e6.push_back(1'b1);
    r_fdata  = 8'h5A;
    r_fstart = 1'b1;
    @(negedge clock);
    r_fstart = 1'b0;
    check("fast_busy", w_fbusy, 1'b1);
    for (int i = 0; i < c_nbits; i++) begin
      check("fast_tx", w_ftx, e6[i]);
      @(negedge clock);
    end
    check("fast_done", w_fdone, 1'b1);
    check("fast_nbusy", w_fbusy, 1'b0);

    // Random start/data traffic against the model
    for (int c = 0; c < 3000; c++) begin
      r_start = ($urandom_range(3) == 0);
      r_data  = 8'($urandom);
      @(negedge clock);
    end
    r_start = 1'b0;
    wait_idle();
    repeat (2) @(negedge clock);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
